output_buffer_reader: RTL and testbench

Drain-side controller for the output result FIFO. After `start`, it reads exactly `RESULT_COUNT` words from the FIFO and presents them to the downstream consumer on a valid/ready stream. A two-entry skid queue lets it sustain one word per cycle across the FIFO's one-cycle read latency. It pulses `done` when the last word has been accepted downstream.

---
 rtl/output_buffer_reader.sv | 107 ++++++++++
 tb/tb_output_buffer_reader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/output_buffer_reader.sv
// Drains RESULT_COUNT words from the result FIFO onto a valid/ready stream.
// A 2-entry skid queue hides the FIFO read latency.
module output_buffer_reader #(
   parameter int DATA_WIDTH   = 16,
   parameter int RESULT_COUNT = 16,
   parameter int CNT_WIDTH    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  buf_empty,
   input  logic [DATA_WIDTH-1:0] buf_dout,
   output logic                  buf_ren,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_WIDTH-1:0]  delivered
);

   typedef enum logic [1:0] {IDLE, DRAIN, FIN} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT  = CNT_WIDTH'(RESULT_COUNT);
   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(RESULT_COUNT - 1);

   state_t                state, state_nxt;
   logic [CNT_WIDTH-1:0]  issued;
   logic [1:0]            occ;
   logic                  inflight;
   logic [DATA_WIDTH-1:0] q0, q1;
   logic                  pop;
   logic [2:0]            level;

   assign out_valid = (occ != 2'd0);
   assign out_data  = q0;
   assign pop       = out_valid & out_ready;
   assign busy      = (state != IDLE);
   assign done      = (state == FIN);
   assign level     = {1'b0, occ} + {2'b00, inflight};

   // Words buffered plus in flight, less the one leaving now, must stay below 2
   assign buf_ren = (state == DRAIN) && !buf_empty && (issued < CNT)
                    && (level < (3'd2 + {2'b00, pop}));

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = DRAIN;
         DRAIN:   if (pop && delivered == LAST) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issued    <= '0;
         delivered <= '0;
         inflight  <= 1'b0;
      end else begin
         inflight <= buf_ren;
         if (state == IDLE && start) begin
            issued    <= '0;
            delivered <= '0;
         end else begin
            if (buf_ren) issued <= issued + 1'b1;
            if (pop)     delivered <= delivered + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ <= 2'd0;
         q0  <= '0;
         q1  <= '0;
      end else begin
         unique case ({inflight, pop})
            2'b10: begin
               if (occ == 2'd0) q0 <= buf_dout;
               else             q1 <= buf_dout;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               q0  <= q1;
               occ <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd2) begin
                  q0 <= q1;
                  q1 <= buf_dout;
               end else begin
                  q0 <= buf_dout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_output_buffer_reader.sv
// Randomized bench for output_buffer_reader with a FIFO model
// and a scoreboard of expected word order.
module tb_output_buffer_reader;

   localparam int RC = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        buf_empty;
   logic [15:0] buf_dout;
   logic        buf_ren;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        done;
   logic [7:0]  delivered;

   output_buffer_reader #(
      .DATA_WIDTH(16), .RESULT_COUNT(RC), .CNT_WIDTH(8)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .buf_empty(buf_empty), .buf_dout(buf_dout), .buf_ren(buf_ren),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done), .delivered(delivered)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   logic [15:0] mem[$];
   logic [15:0] exp_q[$];
   logic [15:0] dout_nxt;
   int          m_acc, m_ren, n_done, cyc;
   bit          m_busy, m_done_next, stall_prev;
   logic [15:0] prev_data;
   logic        s_valid, s_done;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
      end
   endtask

   task automatic fifo_write(input logic [15:0] w);
      mem.push_back(w);
      exp_q.push_back(w);
      buf_empty = 1'b0;
   endtask

   task automatic model_clear();
      mem.delete();
      exp_q.delete();
      m_acc = 0; m_ren = 0; n_done = 0;
      m_busy = 0; m_done_next = 0; stall_prev = 0;
      prev_data = '0;
      dout_nxt = '0;
   endtask

   task automatic step();
      bit acc, ren_s, done_now;
      @(negedge clk);
      ren_s = 0;
      if (!rst) begin
         acc = out_valid & out_ready;
         s_valid = out_valid;
         s_done = done;
         chk("busy", busy, m_busy);
         chk("done", done, m_done_next);
         chk("delivered", delivered, m_acc);
         chk("ren_empty", buf_ren & buf_empty, 0);
         chk("ren_limit", (m_ren + int'(buf_ren)) <= RC, 1);
         chk("outstanding",
             (m_ren - m_acc + int'(buf_ren) - int'(acc)) <= 2, 1);
         if (stall_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, prev_data);
         end
         if (acc) begin
            if (exp_q.size() == 0) chk("data_extra", 1, 0);
            else chk("data", out_data, exp_q.pop_front());
         end
         if (done) n_done++;
         done_now = m_done_next;
         m_done_next = m_busy && acc && (m_acc + 1 == RC);
         if (acc) m_acc++;
         if (buf_ren) m_ren++;
         if (done_now) m_busy = 0;
         else if (!m_busy && start) begin
            m_busy = 1; m_acc = 0; m_ren = 0;
         end
         stall_prev = out_valid & ~out_ready;
         prev_data = out_data;
         ren_s = buf_ren;
      end
      @(posedge clk);
      if (rst) begin
         mem.delete();
         dout_nxt = '0;
      end else if (ren_s) begin
         if (mem.size() > 0) dout_nxt = mem.pop_front();
         else dout_nxt = 16'hdead;
      end
      #1;
      buf_dout = dout_nxt;
      buf_empty = (mem.size() == 0);
      cyc++;
   endtask

   task automatic apply_rst();
      rst = 1'b1;
      start = 1'b0;
      model_clear();
      repeat (2) step();
      rst = 1'b0;
   endtask

   task automatic check_reset_outputs();
      chk("rst_ren", buf_ren, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dlv", delivered, 0);
   endtask

   task automatic do_start();
      n_done = 0;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // mode 0: ready high, 1: 1,0,0,1 pattern, 2: random
   task automatic set_ready(input int mode);
      logic [3:0] pat;
      pat = 4'b1001;
      case (mode)
         0:       out_ready = 1'b1;
         1:       out_ready = pat[cyc % 4];
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic run_until_done(input int mode, input bit poke,
                                 output int steps);
      steps = 0;
      s_done = 0;
      while (!s_done && steps < 400) begin
         set_ready(mode);
         start = poke ? (m_done_next | ($urandom_range(0, 7) == 0)) : 1'b0;
         step();
         steps++;
      end
      start = 1'b0;
      if (!s_done) chk("timeout", 0, 1);
      chk("final_dlv", delivered, RC);
   endtask

   task automatic run_n(input int n, input int mode);
      for (int i = 0; i < n; i++) begin
         set_ready(mode);
         step();
      end
   endtask

   initial begin
      int k, steps;
      cyc = 0;
      rst = 1'b1; start = 1'b0; out_ready = 1'b0;
      buf_empty = 1'b1; buf_dout = '0;
      apply_rst();
      check_reset_outputs();

      // basic drain
      for (int i = 1; i <= 16; i++) fifo_write(16'(i));
      out_ready = 1'b1;
      do_start();
      k = 0;
      s_valid = 0;
      while (!s_valid && k < 10) begin
         step();
         k++;
      end
      chk("latency", k, 3);
      run_until_done(0, 0, steps);
      chk("burst_cycles", steps, 16);
      run_n(2, 0);
      chk("basic_done_cnt", n_done, 1);
      chk("basic_busy", busy, 0);

      // backpressure
      for (int i = 0; i < 16; i++) fifo_write(16'($urandom));
      do_start();
      run_until_done(1, 0, steps);
      run_n(2, 1);
      chk("bp_done_cnt", n_done, 1);

      // empty stall
      for (int i = 0; i < 4; i++) fifo_write(16'($urandom));
      do_start();
      run_n(10, 2);
      chk("stall_dlv", delivered, 4);
      for (int i = 0; i < 12; i++) fifo_write(16'($urandom));
      run_until_done(2, 0, steps);
      run_n(2, 2);
      chk("stall_done_cnt", n_done, 1);

      // over-full FIFO
      for (int i = 0; i < 20; i++) fifo_write(16'($urandom));
      do_start();
      run_until_done(0, 0, steps);
      run_n(3, 0);
      chk("over_ren_cnt", m_ren, 16);
      chk("over_left", mem.size(), 4);
      chk("over_not_empty", buf_empty, 0);
      apply_rst();

      // start while busy and during FIN
      for (int i = 0; i < 16; i++) fifo_write(16'($urandom));
      do_start();
      run_until_done(2, 1, steps);
      run_n(3, 2);
      chk("busy_start_done_cnt", n_done, 1);

      // reset mid-drain
      for (int i = 0; i < 16; i++) fifo_write(16'($urandom));
      out_ready = 1'b1;
      do_start();
      k = 0;
      while (m_acc < 5 && k < 50) begin
         step();
         k++;
      end
      chk("mid_reached", m_acc >= 5, 1);
      rst = 1'b1;
      #1;
      check_reset_outputs();
      apply_rst();
      check_reset_outputs();
      for (int i = 0; i < 16; i++) fifo_write(16'($urandom));
      do_start();
      run_until_done(2, 0, steps);
      run_n(2, 2);
      chk("after_rst_done_cnt", n_done, 1);
      chk("after_rst_left", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
